keccak_rho_pi_pipe: RTL and testbench

- Parametrised, registered successor to the combinational rho step of the Keccak-f permutation engine.
- Applies rho (lane rotation) and, optionally, pi (lane permutation) to a full 5x5xW state, in forward or inverse direction.
- Wrapped in a one-stage valid/ready pipeline register so it can sit between the theta and chi stages of a multi-cycle round datapath.

---
 rtl/keccak_rho_pi_pipe.sv | 121 ++++++++++++
 tb/tb_keccak_rho_pi_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_rho_pi_pipe.sv
// Keccak-f rho (lane rotation) with optional pi (lane permutation), forward or inverse,
// behind a single valid/ready output register with a running count of delivered states.
module keccak_rho_pi_pipe #(
    parameter int W  = 64,
    parameter int SW = 25 * W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_state,
    input  logic [1:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_state,
    output logic [15:0]   out_count
);

    // Rotation offset for the lane stored at index x*5+y.
    function automatic int rho_off(input int lane);
        case (lane)
            0:  rho_off = 0;    1:  rho_off = 36;   2:  rho_off = 3;
            3:  rho_off = 105;  4:  rho_off = 210;  5:  rho_off = 1;
            6:  rho_off = 300;  7:  rho_off = 10;   8:  rho_off = 45;
            9:  rho_off = 66;   10: rho_off = 190;  11: rho_off = 6;
            12: rho_off = 171;  13: rho_off = 15;   14: rho_off = 253;
            15: rho_off = 28;   16: rho_off = 55;   17: rho_off = 153;
            18: rho_off = 21;   19: rho_off = 120;  20: rho_off = 91;
            21: rho_off = 276;  22: rho_off = 231;  23: rho_off = 136;
            24: rho_off = 78;
            default: rho_off = 0;
        endcase
    endfunction

    if (!(W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
        $error("keccak_rho_pi_pipe: W must be 8, 16, 32 or 64");
    end
    if (SW != 25 * W) begin : g_bad_sw
        $error("keccak_rho_pi_pipe: SW must equal 25*W");
    end

    logic [SW-1:0] rho_fwd;
    logic [SW-1:0] rho_inv;
    logic [SW-1:0] pi_fwd;
    logic [SW-1:0] pi_inv;

    // Each lane is rotated by slicing a doubled copy; pi maps lane (x,y) to (y,(2x+3y)%5),
    // and the inverse path reads from that same index, so both share PI_IDX.
    for (genvar gi = 0; gi < 25; gi++) begin : g_lane
        localparam int X      = gi / 5;
        localparam int Y      = gi % 5;
        localparam int PI_IDX = Y * 5 + (2 * X + 3 * Y) % 5;
        localparam int SH     = rho_off(gi) % W;

        logic [2*W-1:0] dbl_own;
        logic [2*W-1:0] dbl_src;

        assign dbl_own = {2{in_state[gi*W +: W]}};
        assign dbl_src = {2{in_state[PI_IDX*W +: W]}};

        assign rho_fwd[gi*W +: W]     = dbl_own[W-SH +: W];
        assign pi_fwd[PI_IDX*W +: W]  = dbl_own[W-SH +: W];
        assign rho_inv[gi*W +: W]     = dbl_own[SH +: W];
        assign pi_inv[gi*W +: W]      = dbl_src[SH +: W];
    end

    logic [SW-1:0] xform_state;

    always_comb begin
        xform_state = rho_fwd;
        case (in_mode)
            2'b00:   xform_state = rho_fwd;
            2'b01:   xform_state = pi_fwd;
            2'b10:   xform_state = rho_inv;
            2'b11:   xform_state = pi_inv;
            default: xform_state = rho_fwd;
        endcase
    end

    logic          valid_q, valid_d;
    logic [SW-1:0] state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic          in_fire;
    logic          out_fire;

    assign in_ready = ~valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = valid_q & out_ready;

    always_comb begin
        valid_d = valid_q;
        state_d = state_q;
        count_d = count_q;
        if (in_fire) begin
            valid_d = 1'b1;
            state_d = xform_state;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
        if (out_fire) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            state_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign out_valid = valid_q;
    assign out_state = state_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_keccak_rho_pi_pipe.sv
// Directed vectors, handshake sequences and per-width round trips for keccak_rho_pi_pipe.
module tb_keccak_rho_pi_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst, rst_rt, rt_go;

    logic          in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    in_mode;
    logic [1599:0] in_state, out_state;
    logic [15:0]   out_count;

    keccak_rho_pi_pipe #(.W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .out_count(out_count)
    );

    logic         v8, ir8, ov8, or8;
    logic [1:0]   m8;
    logic [199:0] s8, os8;
    logic [15:0]  oc8;

    keccak_rho_pi_pipe #(.W(8)) dut8 (
        .clk(clk), .rst(rst_rt), .in_valid(v8), .in_ready(ir8),
        .in_state(s8), .in_mode(m8), .out_valid(ov8),
        .out_ready(or8), .out_state(os8), .out_count(oc8)
    );

    task automatic check_state(input string name, input logic [1599:0] act, input logic [1599:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            errors++;
            k = 0;
            for (int c = 0; c < 25; c++) begin
                if (act[c*64 +: 64] !== exp[c*64 +: 64]) begin
                    k = c;
                    break;
                end
            end
            $display("FAIL %s: chunk %0d got %h want %h", name, k, act[k*64 +: 64], exp[k*64 +: 64]);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [1599:0] mk(input int idx, input logic [63:0] v);
        logic [1599:0] s;
        s = '0;
        s[idx*64 +: 64] = v;
        return s;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_rt
        localparam int WW  = 8 << gi;
        localparam int SWW = 25 * WW;

        logic           v, ir, ov, ordy, done;
        logic [1:0]     m;
        logic [SWW-1:0] s, os;
        logic [15:0]    oc;

        keccak_rho_pi_pipe #(.W(WW)) u_rt (
            .clk(clk), .rst(rst_rt), .in_valid(v), .in_ready(ir),
            .in_state(s), .in_mode(m), .out_valid(ov),
            .out_ready(ordy), .out_state(os), .out_count(oc)
        );

        initial begin
            logic [1631:0]  rnd;
            logic [SWW-1:0] orig;
            logic [1599:0]  a, e;
            done = 1'b0; v = 1'b0; m = 2'b00; s = '0; ordy = 1'b1;
            wait (rt_go);
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                for (int n = 0; n < 1000; n++) begin
                    for (int k = 0; k < 51; k++) rnd[k*32 +: 32] = $urandom;
                    orig = rnd[SWW-1:0];
                    v = 1'b1; m = (p == 0) ? 2'b01 : 2'b00; s = orig;
                    @(posedge clk); #1;
                    m = (p == 0) ? 2'b11 : 2'b10; s = os;
                    @(posedge clk); #1;
                    v = 1'b0;
                    a = '0; a[SWW-1:0] = os;
                    e = '0; e[SWW-1:0] = orig;
                    check_state($sformatf("roundtrip_w%0d_p%0d_n%0d", WW, p, n), a, e);
                end
            end
            done = 1'b1;
        end
    end

    typedef struct {
        logic [1:0]  mode;
        int          in_lane;
        logic [63:0] in_val;
        int          exp_lane;
        logic [63:0] exp_val;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [1599:0] t;
        logic          all_done;

        vecs[0] = '{2'b00, 5,  64'h1,                 5,  64'h2};
        vecs[1] = '{2'b00, 1,  64'h1,                 1,  64'h0000_0010_0000_0000};
        vecs[2] = '{2'b01, 5,  64'h1,                 2,  64'h2};
        vecs[3] = '{2'b01, 0,  64'hDEAD_BEEF,         0,  64'hDEAD_BEEF};
        vecs[4] = '{2'b10, 5,  64'h2,                 5,  64'h1};
        vecs[5] = '{2'b10, 1,  64'h1,                 1,  64'h1000_0000};
        vecs[6] = '{2'b00, 24, 64'h1,                 24, 64'h4000};
        vecs[7] = '{2'b11, 2,  64'h2,                 5,  64'h1};
        vecs[8] = '{2'b01, 13, 64'h1,                 18, 64'h8000};
        vecs[9] = '{2'b00, 17, 64'h8000_0000_0000_0000, 17, 64'h0100_0000};

        rst = 1'b1; rst_rt = 1'b1; rt_go = 1'b0;
        in_valid = 1'b0; in_mode = 2'b00; in_state = '0; out_ready = 1'b1;
        v8 = 1'b0; m8 = 2'b00; s8 = '0; or8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst_rt = 1'b0; rt_go = 1'b1;

        check_val("reset_out_valid", {63'b0, out_valid}, 64'h0);
        check_val("reset_in_ready", {63'b0, in_ready}, 64'h1);
        check_val("reset_out_count", {48'b0, out_count}, 64'h0);
        check_state("reset_out_state", out_state, '0);

        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_mode  = vecs[i].mode;
            in_state = mk(vecs[i].in_lane, vecs[i].in_val);
            @(posedge clk); #1;
            check_val($sformatf("vec%0d_valid", i), {63'b0, out_valid}, 64'h1);
            check_state($sformatf("vec%0d_state", i), out_state, mk(vecs[i].exp_lane, vecs[i].exp_val));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("table_drain_valid", {63'b0, out_valid}, 64'h0);
        check_val("table_count", {48'b0, out_count}, 64'd10);

        v8 = 1'b1; s8 = '0; s8[6*8 +: 8] = 8'h01;
        @(posedge clk); #1;
        t = '0; t[199:0] = os8;
        check_state("w8_lane11_rot4", t, {1592'b0, 8'h10} << (6*8));
        s8 = '0; s8[10*8 +: 8] = 8'h01;
        @(posedge clk); #1;
        v8 = 1'b0;
        t = '0; t[199:0] = os8;
        check_state("w8_lane20_rot6", t, {1592'b0, 8'h40} << (10*8));

        // Backpressure: one capture, four stalled cycles, then drain in order.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'b00; in_state = mk(0, 64'h11);
        @(posedge clk); #1;
        check_val("bp_first_valid", {63'b0, out_valid}, 64'h1);
        in_state = mk(0, 64'h22);
        for (int c = 0; c < 4; c++) begin
            check_val($sformatf("bp_stall%0d_in_ready", c), {63'b0, in_ready}, 64'h0);
            check_state($sformatf("bp_stall%0d_state", c), out_state, mk(0, 64'h11));
            @(posedge clk); #1;
        end
        check_state("bp_hold_state", out_state, mk(0, 64'h11));
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_state("bp_second_out", out_state, mk(0, 64'h22));
        in_state = mk(0, 64'h33);
        @(posedge clk); #1;
        check_state("bp_third_out", out_state, mk(0, 64'h33));
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("bp_drained_valid", {63'b0, out_valid}, 64'h0);
        check_val("bp_count", {48'b0, out_count}, 64'd3);

        // Reset while holding a state, with another input offered during reset.
        out_ready = 1'b0; in_valid = 1'b1; in_state = mk(3, 64'h1234);
        @(posedge clk); #1;
        check_val("mid_held_valid", {63'b0, out_valid}, 64'h1);
        rst = 1'b1; out_ready = 1'b1; in_state = mk(4, 64'h5678);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check_val("mid_rst_valid", {63'b0, out_valid}, 64'h0);
        check_val("mid_rst_count", {48'b0, out_count}, 64'h0);
        check_state("mid_rst_state", out_state, '0);
        in_valid = 1'b1; in_mode = 2'b00; in_state = mk(7, 64'hCAFE);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("post_rst_valid", {63'b0, out_valid}, 64'h1);
        check_state("post_rst_state", out_state, mk(7, 64'h032B_F800));
        @(posedge clk); #1;
        check_val("post_rst_count", {48'b0, out_count}, 64'h1);

        // Stream until the counter reaches 0xFFFF, then one more transfer wraps it.
        in_valid = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("count_max", {48'b0, out_count}, 64'hFFFF);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_val("count_wrap", {48'b0, out_count}, 64'h0);

        all_done = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            all_done = g_rt[0].done & g_rt[1].done & g_rt[2].done & g_rt[3].done;
            if (all_done) break;
            @(posedge clk);
        end
        checks++;
        if (!all_done) begin
            errors++;
            $display("FAIL roundtrip_timeout: got not-done want done");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
